// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter driving a shared 2:1 data mux.
// Ties go to the requester not served last; a grant ends on drop or after BURST_LEN transfers.
module mux_arbiter #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              out_ready,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);

  state_t     state;
  logic [3:0] beat;
  logic       last_served;
  logic       xfer;
  logic       last_beat;

  assign out_data  = sel ? data_b : data_a;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer      = out_valid & out_ready;
  assign last_beat = (beat == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sel         <= 1'b0;
      beat        <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // last_served=1 means B went last, so A takes a tie
          if (req_a && (!req_b || last_served)) begin
            state <= GRANT_A;
            gnt_a <= 1'b1;
            gnt_b <= 1'b0;
            sel   <= 1'b0;
            beat  <= '0;
          end else if (req_b) begin
            state <= GRANT_B;
            gnt_a <= 1'b0;
            gnt_b <= 1'b1;
            sel   <= 1'b1;
            beat  <= '0;
          end
        end
        GRANT_A: begin
          if (!req_a || (xfer && last_beat)) begin
            last_served <= 1'b0;
            gnt_a       <= 1'b0;
            beat        <= '0;
            if (req_b) begin
              state <= GRANT_B;
              gnt_b <= 1'b1;
              sel   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat <= beat + 4'd1;
          end
        end
        GRANT_B: begin
          if (!req_b || (xfer && last_beat)) begin
            last_served <= 1'b1;
            gnt_b       <= 1'b0;
            beat        <= '0;
            if (req_a) begin
              state <= GRANT_A;
              gnt_a <= 1'b1;
              sel   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat <= beat + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against an ownership/burst-count reference model.
module tb_mux_arbiter;

  localparam int unsigned DW = 4;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, req_b, out_ready;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, sel, out_valid;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .out_ready(out_ready),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ra, rb, rdy;
    logic [DW-1:0] da, db;
    logic          ga, gb, sl, vl;
    logic [DW-1:0] dt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic ra, rb, rdy, input logic ga, gb, sl, vl, input logic [DW-1:0] dt);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rdy = rdy; v.da = 4'h5; v.db = 4'hA;
    v.ga = ga; v.gb = gb; v.sl = sl; v.vl = vl; v.dt = dt;
    vecs.push_back(v);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: who owns the mux and how many transfers it has made.
  int owner;       // 0 none, 1 A, 2 B
  int done_beats;
  int last;        // 1 = A served last, 2 = B served last
  logic msel;

  task automatic model_reset();
    owner = 0; done_beats = 0; last = 2; msel = 1'b0;
  endtask

  task automatic model_grant(input int who);
    owner = who; done_beats = 0; msel = (who == 2);
  endtask

  task automatic model_step(input logic rst, ra, rb, rdy);
    logic mine, other, valid, finished;
    if (rst) begin
      model_reset();
      return;
    end
    if (owner == 0) begin
      if (ra && rb) model_grant(last == 1 ? 2 : 1);
      else if (ra)  model_grant(1);
      else if (rb)  model_grant(2);
    end else begin
      mine     = (owner == 1) ? ra : rb;
      other    = (owner == 1) ? rb : ra;
      valid    = mine;
      finished = !mine || (valid && rdy && (done_beats + 1 == int'(BL)));
      if (finished) begin
        last = owner;
        if (other) model_grant(3 - owner);
        else begin owner = 0; done_beats = 0; end
      end else if (valid && rdy) begin
        done_beats++;
      end
    end
  endtask

  initial begin
    logic [11:0] pat;
    int          nx;
    logic        rst_r;
    logic [7:0]  exp_v;

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    data_a = 4'h5; data_b = 4'hA;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", {gnt_a, gnt_b, sel, out_valid}, 4'b0000);

    // {ra,rb,rdy} | expected {gnt_a,gnt_b,sel,out_valid,out_data} before that cycle's edge
    add(1,1,1, 0,0,0,0, 4'h5);
    for (int i = 0; i < 4; i++) add(1,1,1, 1,0,0,1, 4'h5);
    for (int i = 0; i < 4; i++) add(1,1,1, 0,1,1,1, 4'hA);
    for (int i = 0; i < 3; i++) add(1,1,0, 1,0,0,1, 4'h5);
    add(1,1,1, 1,0,0,1, 4'h5);
    add(1,1,1, 1,0,0,1, 4'h5);
    add(0,1,1, 1,0,0,0, 4'h5);
    add(0,1,1, 0,1,1,1, 4'hA);
    add(0,0,1, 0,1,1,0, 4'hA);
    add(1,1,1, 0,0,1,0, 4'hA);
    add(1,1,1, 1,0,0,1, 4'h5);

    @(negedge clk);
    foreach (vecs[i]) begin
      req_a = vecs[i].ra; req_b = vecs[i].rb; out_ready = vecs[i].rdy;
      data_a = vecs[i].da; data_b = vecs[i].db;
      #1;
      check($sformatf("vec%0d", i), {gnt_a, gnt_b, sel, out_valid, out_data},
            {vecs[i].ga, vecs[i].gb, vecs[i].sl, vecs[i].vl, vecs[i].dt});
      @(negedge clk);
    end

    // Lone requester B: forced hand-over inserts one idle cycle between bursts
    apply_reset();
    req_b = 1'b1; out_ready = 1'b1;
    pat = '0; nx = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      pat = {pat[10:0], gnt_b};
      if (out_valid && out_ready) nx++;
      @(negedge clk);
    end
    check("lone_b_pattern", 32'(pat), 32'b0111_1011_1101);
    check("lone_b_xfers", nx, 9);

    // Reset in the middle of a B burst
    apply_reset();
    req_b = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_reset", {gnt_a, gnt_b, sel, out_valid}, 4'b0000);
    req_a = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_tie", {gnt_a, gnt_b, sel, out_data}, {3'b100, 4'h5});
    @(negedge clk);

    // Random traffic against the reference model
    apply_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      rst_r     = ($urandom_range(0, 59) == 0);
      reset     = rst_r;
      req_a     = ($urandom_range(0, 9) < 7);
      req_b     = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 3) != 0);
      data_a    = 4'($urandom);
      data_b    = 4'($urandom);
      #1;
      exp_v = {owner == 1, owner == 2, msel,
               (owner == 1 && req_a) || (owner == 2 && req_b),
               msel ? data_b : data_a};
      check($sformatf("rand%0d", n), {gnt_a, gnt_b, sel, out_valid, out_data}, 32'(exp_v));
      model_step(rst_r, req_a, req_b, out_ready);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 4: width of each requester data bus and the output bus.
REQ-002 Parameter BURST_LEN, default 4: maximum transfers per grant before forced hand-over; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_a  input  1  requester A has data to send.
REQ-006 data_a  input  DATA_W  requester A data; held stable while req_a=1 and not accepted.
REQ-007 req_b  input  1  requester B has data to send.
REQ-008 data_b  input  DATA_W  requester B data; same stability rule.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 gnt_a  output  1  A owns the shared mux (registered).
REQ-011 gnt_b  output  1  B owns the shared mux (registered).
REQ-012 sel  output  1  mux select: 0 = data_a, 1 = data_b (registered).
REQ-013 out_data  output  DATA_W  sel ? data_b : data_a (combinational 2:1 mux).
REQ-014 out_valid  output  1  (gnt_a & req_a) | (gnt_b & req_b), combinational.

Function
REQ-015 FSM states SHALL be IDLE, GRANT_A, GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B; never both.
REQ-016 Transfer SHALL occur on any cycle with out_valid=1 and out_ready=1; no other cycle counts as a transfer.
REQ-017 Internal last_served flag (0=A, 1=B) SHALL decide ties: when both requests are pending, the requester not last served wins.
REQ-018 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> per REQ-017; neither -> stay IDLE; grant visible the cycle after the request is sampled (1-cycle latency).
REQ-019 On entering GRANT_x, sel SHALL switch to x on the same edge as gnt_x; sel holds its last value in IDLE.
REQ-020 beat counter (4 bits) SHALL clear on entering any GRANT state and increment on each transfer.
REQ-021 GRANT_x exit when req_x=0 (requester dropped) or a transfer occurs with beat counter = BURST_LEN-1; otherwise stay.
REQ-022 On exit: if the other requester's req is high that cycle -> go directly to GRANT_other (no IDLE bubble); else -> IDLE.
REQ-023 last_served SHALL update to x on the exit edge from GRANT_x.
REQ-024 out_ready=0 with out_valid=1 SHALL stall: state, counter, grant and sel unchanged.
REQ-025 With BURST_LEN=1, every transfer SHALL cause a grant hand-over evaluation.
REQ-026 A single requester alone SHALL be re-granted after a forced exit: GRANT_x -> IDLE -> GRANT_x (one idle cycle).

Reset
REQ-027 reset=1 at a rising edge SHALL force, on that edge: state=IDLE, gnt_a=0, gnt_b=0, sel=0, beat counter=0, last_served=1 (A wins first tie).
REQ-028 reset SHALL override any in-progress grant or stalled transfer; no transfer is counted in a reset cycle and out_valid=0 the cycle after.

Verification
REQ-029 Reset, then req_a=req_b=1 same cycle -> next cycle gnt_a=1, sel=0; out_data=data_a (e.g. 4'h5).
REQ-030 BURST_LEN=4, both requesting, out_ready=1 constantly -> 4 transfers of A, then gnt_b=1 next cycle with no idle gap, 4 transfers of B, then back to A.
REQ-031 A granted, out_ready=0 for 3 cycles -> out_valid=1, out_data constant, gnt_a held, counter unchanged; transfer on 4th cycle when out_ready=1.
REQ-032 A granted, req_a drops after 2 transfers, req_b=1 -> next cycle gnt_b=1, sel=1, out_data=data_b (e.g. 4'hA); last_served=A.
REQ-033 Only req_b high for 9 transfers, BURST_LEN=4 -> grant pattern 4 beats, 1 IDLE cycle, 4 beats, 1 IDLE cycle, 1 beat.
REQ-034 reset pulsed mid-burst in GRANT_B -> next cycle gnt_a=gnt_b=0, sel=0, out_valid=0; subsequent tie goes to A.
